// File: rtl/gfx_pkg.sv
// Shared graphics constants and types for the frame sink: screen geometry,
// tile size, colour width, sink state encoding and the buffered pixel record.
package gfx_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int TILE_SIZE = 16;
    localparam int COLOUR_W  = 3;

    typedef enum logic [1:0] {
        SINK_IDLE   = 2'd0,
        SINK_ACTIVE = 2'd1,
        SINK_DRAIN  = 2'd2
    } sink_state_t;

    typedef struct packed {
        logic [8:0]          x;
        logic [7:0]          y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small pixel FIFO with registered pointers and a combinational head read.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module pixel_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  logic   pop,
    input  pixel_t wdata,
    output pixel_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    pixel_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/frame_draw_sink.sv
// Pixel-stream sink: converts offsets to screen x/y, buffers them and plots
// through the VGA adapter. Optional macro FRAME_SINK_TRANSPARENT_EN drops key-colour tile pixels.
module frame_draw_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = gfx_pkg::SCREEN_W,
    parameter int SCREEN_H   = gfx_pkg::SCREEN_H
`ifdef FRAME_SINK_TRANSPARENT_EN
    ,
    parameter logic [gfx_pkg::COLOUR_W-1:0] KEY_COLOUR = 3'b101
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        mode_tile,
    input  logic [4:0]  tile_x,
    input  logic [3:0]  tile_y,
    input  logic        in_valid,
    input  logic [16:0] in_offset,
    input  logic [2:0]  in_colour,
    input  logic        in_finished,
    input  logic        vga_ready,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [16:0] pix_count
);

    import gfx_pkg::*;

    localparam logic [1:0] ST_IDLE   = SINK_IDLE;
    localparam logic [1:0] ST_ACTIVE = SINK_ACTIVE;
    localparam logic [1:0] ST_DRAIN  = SINK_DRAIN;
    localparam logic [8:0] X_LIM     = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM     = 8'(SCREEN_H);

    logic [1:0] state;
    logic       mode_tile_q;
    logic [4:0] tile_x_q;
    logic [3:0] tile_y_q;

    pixel_t conv;
    pixel_t head;
    logic   in_range;
    logic   keyed;
    logic   push_req;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    logic   load;
    logic   drop;

    always_comb begin
        conv = '0;
        if (mode_tile_q) begin
            conv.x = 9'(tile_x_q) * 9'(TILE_SIZE) + 9'(in_offset[3:0]);
            conv.y = 8'(tile_y_q) * 8'(TILE_SIZE) + 8'(in_offset[7:4]);
        end else begin
            conv.x = in_offset[8:0];
            conv.y = in_offset[16:9];
        end
        conv.colour = in_colour;
    end

`ifdef FRAME_SINK_TRANSPARENT_EN
    assign keyed = mode_tile_q && (in_colour == KEY_COLOUR);
`else
    assign keyed = 1'b0;
`endif

    assign in_range  = (conv.x < X_LIM) && (conv.y < Y_LIM);
    assign push_req  = (state == ST_ACTIVE) && in_valid && in_range && !keyed;
    assign load      = !vga_plot || vga_ready;
    assign fifo_pop  = load && !fifo_empty;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && fifo_full && !fifo_pop;
    assign busy      = (state != ST_IDLE);

    pixel_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (conv),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mode_tile_q <= 1'b0;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            pix_count   <= '0;
        end else begin
            done <= 1'b0;
            if (drop) overflow <= 1'b1;
            if (vga_plot && vga_ready && (pix_count != '1)) pix_count <= pix_count + 1'b1;
            case (state)
                ST_IDLE: if (start) begin
                    state       <= ST_ACTIVE;
                    mode_tile_q <= mode_tile;
                    tile_x_q    <= tile_x;
                    tile_y_q    <= tile_y;
                    overflow    <= 1'b0;
                    pix_count   <= '0;
                end
                ST_ACTIVE: if (in_finished) state <= ST_DRAIN;
                // Leave only once the last plot has been taken by the adapter.
                ST_DRAIN: if (fifo_empty && !vga_plot) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else if (load) begin
            vga_plot <= !fifo_empty;
            if (!fifo_empty) begin
                vga_x      <= head.x;
                vga_y      <= head.y;
                vga_colour <= head.colour;
            end
        end
    end

endmodule

// File: tb/tb_frame_draw_sink.sv
// Self-checking bench for frame_draw_sink: directed scenarios plus random
// transfers, compared every cycle against a queue-based reference model.
module tb_frame_draw_sink;

    localparam int         DEPTH = 4;
    localparam logic [2:0] KEY   = 3'b101;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode_tile = 1'b0;
    logic [4:0]  tile_x = '0;
    logic [3:0]  tile_y = '0;
    logic        in_valid = 1'b0;
    logic [16:0] in_offset = '0;
    logic [2:0]  in_colour = '0;
    logic        in_finished = 1'b0;
    logic        vga_ready = 1'b0;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [16:0] pix_count;

    frame_draw_sink #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_tile(mode_tile),
        .tile_x(tile_x), .tile_y(tile_y), .in_valid(in_valid), .in_offset(in_offset),
        .in_colour(in_colour), .in_finished(in_finished), .vga_ready(vga_ready),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .done(done), .overflow(overflow), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    // Reference model: 0 idle, 1 accepting pixels, 2 draining
    int   m_state = 0;
    pix_s q[$];
    bit   m_plot = 0;
    pix_s m_out = '0;
    int   m_cnt = 0;
    bit   m_ovf = 0;
    bit   m_done = 0;
    bit   m_mode = 0;
    int   m_tx = 0;
    int   m_ty = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit   acc, ld, pop, empty_before, plot_before, inr, keyed;
        int   off, x, y;
        pix_s p;
        if (!reset_n) begin
            m_state = 0; q.delete(); m_plot = 0; m_out = '0;
            m_cnt = 0; m_ovf = 0; m_done = 0; m_mode = 0; m_tx = 0; m_ty = 0;
            return;
        end
        acc = m_plot && vga_ready;
        ld  = !m_plot || vga_ready;
        empty_before = (q.size() == 0);
        plot_before  = m_plot;
        pop = ld && !empty_before;
        m_done = 0;
        if (pop) begin
            m_out  = q.pop_front();
            m_plot = 1;
        end else if (ld) begin
            m_plot = 0;
        end
        if (m_state == 1 && in_valid) begin
            off = int'(in_offset);
            if (m_mode) begin
                x = m_tx * 16 + (off % 16);
                y = m_ty * 16 + ((off / 16) % 16);
            end else begin
                x = off % 512;
                y = off / 512;
            end
            inr = (x < 320) && (y < 240);
`ifdef FRAME_SINK_TRANSPARENT_EN
            keyed = m_mode && (in_colour == KEY);
`else
            keyed = 0;
`endif
            if (inr && !keyed) begin
                p.x = 9'(x); p.y = 8'(y); p.c = in_colour;
                if (q.size() < DEPTH) q.push_back(p);
                else m_ovf = 1;
            end
        end
        if (acc && m_cnt != 17'h1FFFF) m_cnt++;
        case (m_state)
            0: if (start) begin
                m_state = 1; m_mode = mode_tile; m_tx = int'(tile_x); m_ty = int'(tile_y);
                m_cnt = 0; m_ovf = 0;
            end
            1: if (in_finished) m_state = 2;
            default: if (empty_before && !plot_before) begin m_state = 0; m_done = 1; end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("vga_plot", vga_plot, m_plot);
        chk("busy", busy, m_state != 0);
        chk("done", done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("pix_count", pix_count, m_cnt);
        if (m_plot) begin
            chk("vga_x", vga_x, m_out.x);
            chk("vga_y", vga_y, m_out.y);
            chk("vga_colour", vga_colour, m_out.c);
        end
        if (done) done_cnt++;
    endtask

    task automatic do_start(input logic md, input logic [4:0] tx, input logic [3:0] ty);
        start = 1; mode_tile = md; tile_x = tx; tile_y = ty;
        cycle();
        start = 0;
    endtask

    task automatic drive_pix(input logic [16:0] off, input logic [2:0] col, input logic fin);
        in_valid = 1; in_offset = off; in_colour = col; in_finished = fin;
        cycle();
        in_valid = 0; in_finished = 0;
    endtask

    task automatic finish_pulse();
        in_finished = 1;
        cycle();
        in_finished = 0;
    endtask

    // rdy_mode: 0 hold vga_ready, 1 toggle, 2 random
    task automatic wait_idle(input int bound, input int rdy_mode, input string tag);
        int i;
        i = 0;
        while (busy && i < bound) begin
            if (rdy_mode == 1) vga_ready = ~vga_ready;
            else if (rdy_mode == 2) vga_ready = ($urandom_range(0, 3) != 0);
            cycle();
            i++;
        end
        chk({tag, "_drain_bound"}, busy, 0);
    endtask

    initial begin
        int d0;
        logic [2:0] col;

        // Reset state
        reset_n = 0;
        cycle(); cycle();
        chk("rst_plot", vga_plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_pix_count", pix_count, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_y", vga_y, 0);
        chk("rst_colour", vga_colour, 0);
        reset_n = 1;
        cycle();

        // Full tile sweep at tile (2,1)
        d0 = done_cnt;
        vga_ready = 1;
        do_start(1, 5'd2, 4'd1);
        for (int i = 0; i < 256; i++) drive_pix(17'(i), 3'($urandom_range(0, 7)), i == 255);
        wait_idle(100, 0, "tile_sweep");
        cycle();
        chk("tile_sweep_count", pix_count, 256);
        chk("tile_sweep_done_once", done_cnt - d0, 1);

        // Full-screen corner and clipped pixel
        do_start(0, 5'd0, 4'd0);
        drive_pix(17'(239 * 512 + 319), 3'd6, 0);
        cycle();
        chk("corner_x", vga_x, 319);
        chk("corner_y", vga_y, 239);
        drive_pix(17'd320, 3'd1, 1);
        wait_idle(50, 0, "clip");
        chk("clip_count", pix_count, 1);

        // Stalled adapter: output holds, FIFO fills, extra pixel dropped
        vga_ready = 0;
        do_start(1, 5'd0, 4'd0);
        for (int i = 0; i < DEPTH + 2; i++) drive_pix(17'(i), 3'(i), 0);
        cycle(); cycle();
        chk("stall_overflow", overflow, 1);
        chk("stall_plot", vga_plot, 1);
        chk("stall_hold_x", vga_x, 0);
        vga_ready = 1;
        finish_pulse();
        wait_idle(50, 0, "stall");
        chk("stall_count", pix_count, DEPTH + 1);
        chk("stall_overflow_sticky", overflow, 1);

        // Finish with pending pixels while the adapter toggles ready
        d0 = done_cnt;
        vga_ready = 0;
        do_start(1, 5'd19, 4'd14);
        chk("start_clears_overflow", overflow, 0);
        chk("start_clears_count", pix_count, 0);
        drive_pix(17'h0FF, 3'd2, 0);
        drive_pix(17'h000, 3'd3, 0);
        drive_pix(17'h05A, 3'd4, 0);
        finish_pulse();
        wait_idle(50, 1, "toggle");
        cycle(); cycle();
        chk("toggle_count", pix_count, 3);
        chk("toggle_done_once", done_cnt - d0, 1);

        // Reset in the middle of a transfer
        d0 = done_cnt;
        vga_ready = 0;
        do_start(0, 5'd0, 4'd0);
        for (int i = 0; i < 3; i++) drive_pix(17'(i * 513), 3'd7, 0);
        reset_n = 0;
        cycle();
        chk("midrst_plot", vga_plot, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", pix_count, 0);
        reset_n = 1;
        vga_ready = 1;
        cycle();
        do_start(1, 5'd5, 4'd3);
        for (int i = 0; i < 4; i++) drive_pix(17'(i * 17), 3'd1, i == 3);
        wait_idle(50, 0, "restart");
        cycle();
        chk("restart_count", pix_count, 4);
        chk("midrst_no_done", done_cnt - d0, 1);

        // Key colour in tile mode and in full mode
        vga_ready = 1;
        do_start(1, 5'd1, 4'd1);
        for (int i = 0; i < 4; i++) drive_pix(17'(i), KEY, i == 3);
        wait_idle(50, 0, "key_tile");
`ifdef FRAME_SINK_TRANSPARENT_EN
        chk("key_tile_count", pix_count, 0);
`else
        chk("key_tile_count", pix_count, 4);
`endif
        do_start(0, 5'd0, 4'd0);
        for (int i = 0; i < 3; i++) drive_pix({8'd10, 9'(20 + i)}, KEY, i == 2);
        wait_idle(50, 0, "key_full");
        chk("key_full_count", pix_count, 3);

        // Random transfers
        for (int t = 0; t < 6; t++) begin
            vga_ready = 1;
            do_start(1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), 4'($urandom_range(0, 14)));
            for (int c = 0; c < 80; c++) begin
                vga_ready = ($urandom_range(0, 3) != 0);
                col = ($urandom_range(0, 3) == 0) ? KEY : 3'($urandom_range(0, 7));
                in_valid = 1'($urandom_range(0, 1));
                in_offset = 17'($urandom_range(0, 17'h1FFFF));
                in_colour = col;
                cycle();
            end
            in_valid = 0;
            finish_pulse();
            wait_idle(200, 2, "random");
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
